// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending controller.
package irq_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Downstream grant handshake: valid/idx are driven by the controller, ack by the consumer.
// valid/ack rule: a grant is transferred on the rising edge where irq_valid and irq_ack are both 1;
// irq_idx is stable for as long as irq_valid is high, and irq_ack without irq_valid has no effect.
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic             irq_valid;
  logic [IDX_W-1:0] irq_idx;
  logic             irq_ack;

  modport master (output irq_valid, output irq_idx, input irq_ack);
  modport slave  (input irq_valid, input irq_idx, output irq_ack);
endinterface

// File: rtl/irq_pending_ctrl_pri_enc.sv
// Combinational 8:3 priority encoder; the highest set index wins.
module pri_enc_8to3
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any_set
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any_set = |req;
endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending capture with per-line mask, fixed-priority grant and valid/ack release.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   irq_in,
  input  logic [N_REQ-1:0]   mask,
  input  logic               clr_all,
  irq_pending_ctrl_if.master irq,
  output logic [N_REQ-1:0]   pending,
  output logic [N_REQ-1:0]   ovf,
  output state_t             state
);
  logic [N_REQ-1:0] irq_q;
  logic [N_REQ-1:0] ev;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] ack_clr;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             ack_fire;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;

  assign ev       = EDGE ? (irq_in & ~irq_q) : irq_in;
  assign eligible = pending & mask;
  assign ack_fire = (state == HOLD) && irq.irq_ack;

  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[idx_q] = 1'b1;
  end

  pri_enc_8to3 u_enc (
    .req     (eligible),
    .idx     (enc_idx),
    .any_set (enc_any)
  );

  // History resets to 0 so a line already high at reset release counts as an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_in;
  end

  // A new event wins over the ack-clear of the same bit; that case is not an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= '0;
    end else if (clr_all) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~ack_clr) | ev;
      ovf     <= ovf | (ev & pending & ~ack_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_any && !clr_all) begin
            state   <= HOLD;
            valid_q <= 1'b1;
            idx_q   <= enc_idx;
          end
        end
        HOLD: begin
          if (clr_all || irq.irq_ack) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq.irq_valid = valid_q;
  assign irq.irq_idx   = idx_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of pending/ovf/grant.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       clr_all;
  logic [7:0] pending;
  logic [7:0] ovf;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl #(.EDGE(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .mask    (mask),
    .clr_all (clr_all),
    .irq     (bus.master),
    .pending (pending),
    .ovf     (ovf),
    .state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  bit   m_pend [8];
  bit   m_ovf  [8];
  bit   m_prev [8];
  bit   m_valid;
  int   m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
      end
      m_valid = 0;
      m_idx   = 0;
    end else begin
      bit ev [8];
      int acked;
      int grant;
      for (int i = 0; i < 8; i++) begin
        ev[i]     = irq_in[i] && !m_prev[i];
        m_prev[i] = irq_in[i];
      end
      if (clr_all) begin
        for (int i = 0; i < 8; i++) begin
          m_pend[i] = 0; m_ovf[i] = 0;
        end
        m_valid = 0;
      end else begin
        acked = (m_valid && bus.irq_ack) ? m_idx : -1;
        grant = -1;
        if (!m_valid) begin
          for (int i = 7; i >= 0; i--) begin
            if (grant < 0 && m_pend[i] && mask[i]) grant = i;
          end
        end
        for (int i = 0; i < 8; i++) begin
          if (ev[i]) begin
            if (m_pend[i] && i != acked) m_ovf[i] = 1;
            m_pend[i] = 1;
          end else if (i == acked) begin
            m_pend[i] = 0;
          end
        end
        if (acked >= 0) m_valid = 0;
        else if (grant >= 0) begin
          m_valid = 1;
          m_idx   = grant;
        end
      end
    end
  end

  function automatic logic [7:0] pack8(input bit a [8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[i];
    return r;
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit check_en = 0;

  always @(negedge clk) begin
    if (check_en) begin
      logic [7:0] exp_q[$];
      exp_q.push_back({7'd0, m_valid});
      exp_q.push_back(pack8(m_pend));
      exp_q.push_back(pack8(m_ovf));
      chk("model_valid",   {7'd0, bus.irq_valid}, exp_q.pop_front());
      chk("model_pending", pending,               exp_q.pop_front());
      chk("model_ovf",     ovf,                   exp_q.pop_front());
      if (m_valid) chk("model_idx", {5'd0, bus.irq_idx}, 8'(m_idx));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] irq, input logic ack, input logic clr);
    irq_in      = irq;
    bus.irq_ack = ack;
    clr_all     = clr;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [2:0] idx,
                            input logic [7:0] pend, input logic [7:0] ov);
    chk({name, "_valid"},   {7'd0, bus.irq_valid}, {7'd0, v});
    if (v) chk({name, "_idx"}, {5'd0, bus.irq_idx}, {5'd0, idx});
    chk({name, "_pending"}, pending, pend);
    chk({name, "_ovf"},     ovf,     ov);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    mask  = 8'hFF;
    drive(8'h00, 1'b0, 1'b0);
    tick(); tick();
    expect_out("reset", 1'b0, 3'd0, 8'h00, 8'h00);
    rst_n = 1'b1;
    check_en = 1;
    tick();

    // single held line
    drive(8'h04, 0, 0); tick();
    expect_out("t1_capture", 0, 3'd0, 8'h04, 8'h00);
    tick();
    expect_out("t1_grant", 1, 3'd2, 8'h04, 8'h00);
    drive(8'h04, 1, 0); tick();
    expect_out("t1_ack", 0, 3'd0, 8'h00, 8'h00);
    drive(8'h00, 0, 0); tick();

    // simultaneous events, highest index first
    drive(8'h81, 0, 0); tick();
    drive(8'h00, 0, 0); tick();
    expect_out("t2_grant7", 1, 3'd7, 8'h81, 8'h00);
    drive(8'h00, 1, 0); tick();
    expect_out("t2_gap", 0, 3'd0, 8'h01, 8'h00);
    drive(8'h00, 0, 0); tick();
    expect_out("t2_grant0", 1, 3'd0, 8'h01, 8'h00);
    drive(8'h00, 1, 0); tick();
    drive(8'h00, 0, 0); tick();

    // frozen index while holding
    drive(8'h02, 0, 0); tick();
    drive(8'h00, 0, 0); tick();
    expect_out("t3_grant1", 1, 3'd1, 8'h02, 8'h00);
    drive(8'h40, 0, 0); tick();
    drive(8'h00, 0, 0); tick();
    expect_out("t3_frozen", 1, 3'd1, 8'h42, 8'h00);
    drive(8'h00, 1, 0); tick();
    drive(8'h00, 0, 0); tick();
    expect_out("t3_grant6", 1, 3'd6, 8'h40, 8'h00);
    drive(8'h00, 1, 0); tick();
    drive(8'h00, 0, 0); tick();

    // masked line captured, granted once unmasked
    mask = 8'hEF;
    drive(8'h10, 0, 0); tick();
    drive(8'h00, 0, 0); tick(); tick();
    expect_out("t4_masked", 0, 3'd0, 8'h10, 8'h00);
    mask = 8'hFF; tick();
    expect_out("t4_unmask", 1, 3'd4, 8'h10, 8'h00);
    drive(8'h00, 1, 0); tick();
    drive(8'h00, 0, 0); tick();

    // overflow and event-vs-ack on the same line
    drive(8'h08, 0, 0); tick();
    drive(8'h00, 0, 0); tick();
    drive(8'h08, 0, 0); tick();
    expect_out("t5_ovf", 1, 3'd3, 8'h08, 8'h08);
    drive(8'h00, 0, 0); tick();
    drive(8'h08, 1, 0); tick();
    expect_out("t5_ev_ack", 0, 3'd0, 8'h08, 8'h08);
    drive(8'h00, 0, 0); tick();
    expect_out("t5_regrant", 1, 3'd3, 8'h08, 8'h08);
    drive(8'h00, 1, 0); tick();

    // flush during hold
    drive(8'h00, 0, 1); tick();
    drive(8'h3C, 0, 0); tick();
    drive(8'h00, 0, 0); tick();
    drive(8'h04, 0, 0); tick();
    drive(8'h00, 0, 0);
    expect_out("t6_pre", 1, 3'd5, 8'h3C, 8'h04);
    drive(8'h00, 0, 1); tick();
    expect_out("t6_clr", 0, 3'd0, 8'h00, 8'h00);
    drive(8'h00, 0, 0); tick();

    // async reset mid-hold
    drive(8'h20, 0, 0); tick();
    drive(8'h00, 0, 0); tick();
    expect_out("t6_hold", 1, 3'd5, 8'h20, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    expect_out("t6_async_rst", 0, 3'd0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] r;
      r = 8'(1) << $urandom_range(0, 7);
      irq_in      = ($urandom_range(0, 3) == 0) ? (irq_in ^ r) : irq_in;
      mask        = ($urandom_range(0, 7) == 0) ? 8'($urandom) : mask;
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      clr_all     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    check_en = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
